// File: rtl/uart_pkg.sv
// Constants shared by the UART transmit and receive sides: the FSM state
// encoding, the parity-type values and the idle level of the serial line.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;
  localparam logic LINE_IDLE   = 1'b1;

  // Width of a counter that indexes DATA_WIDTH bits (at least one bit).
  function automatic int unsigned bit_index_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Shadow data shift register for the UART transmitter. cur_bit is always the
// next data bit to be placed on the line; each shift consumes it. The bit
// index is preset to all-ones on load so the shift that starts the first data
// bit wraps it to 0, after which it names the bit currently on the line.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  parity_type,
  output logic                  cur_bit,
  output logic                  last_bit,
  output logic                  parity_bit
);

  localparam int IDX_W = bit_index_width(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shreg;
  logic [IDX_W-1:0]      idx;
  logic                  parity_q;

  // Capture the byte and its parity on load; shift one bit per data bit sent.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; the shadow registers are reset too, because the
  // frame must be discarded cleanly when reset hits mid-transmission.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      shreg    <= '0;
      idx      <= '0;
      parity_q <= 1'b0;
    end else if (load) begin
      shreg    <= data;
      idx      <= '1;
      parity_q <= (parity_type == PARITY_ODD) ? ~^data : ^data;
    end else if (shift) begin
      shreg <= shreg >> 1;
      idx   <= idx + IDX_W'(1);
    end
  end

  assign cur_bit    = shreg[0];
  assign last_bit   = (idx == LAST_IDX);
  assign parity_bit = parity_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional
// parity bit, one stop bit. Every bit lasts max(Prescale, 1) clock cycles.
// Frame parameters are latched when a request is accepted in IDLE, so input
// changes during a frame have no effect. TX_OUT and Busy come straight from
// flops; each is loaded with the value for the state being entered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic [DATA_WIDTH-1:0]     P_Data,
  input  logic                      Data_valid,
  input  logic                      Parity_EN,
  input  logic                      Parity_type,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      Busy
);

  uart_state_e               state;
  logic [PRESCALE_WIDTH-1:0] bit_cnt;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [PRESCALE_WIDTH-1:0] bit_last;
  logic                      parity_en_q;
  logic                      tick;
  logic                      load;
  logic                      shift;
  logic                      cur_bit;
  logic                      last_bit;
  logic                      parity_bit;

  // Prescale values 0 and 1 both give a one-cycle bit period.
  assign bit_last = (prescale_q == '0) ? '0 : prescale_q - PRESCALE_WIDTH'(1);
  assign tick     = (bit_cnt == bit_last);
  assign load     = (state == ST_IDLE) && Data_valid;
  assign shift    = tick && ((state == ST_START) ||
                             ((state == ST_DATA) && !last_bit));

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_serializer (
    .CLK         (CLK),
    .Reset       (Reset),
    .load        (load),
    .shift       (shift),
    .data        (P_Data),
    .parity_type (Parity_type),
    .cur_bit     (cur_bit),
    .last_bit    (last_bit),
    .parity_bit  (parity_bit)
  );

  // Frame FSM with bit timer and registered line/busy outputs.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      prescale_q  <= '0;
      parity_en_q <= 1'b0;
      TX_OUT      <= LINE_IDLE;
      Busy        <= 1'b0;
    end else begin
      if (state != ST_IDLE) begin
        bit_cnt <= tick ? '0 : bit_cnt + PRESCALE_WIDTH'(1);
      end
      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          TX_OUT  <= LINE_IDLE;
          Busy    <= 1'b0;
          if (Data_valid) begin
            prescale_q  <= Prescale;
            parity_en_q <= Parity_EN;
            state       <= ST_START;
            TX_OUT      <= 1'b0;
            Busy        <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            state  <= ST_DATA;
            TX_OUT <= cur_bit;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (!last_bit) begin
              TX_OUT <= cur_bit;
            end else if (parity_en_q) begin
              state  <= ST_PARITY;
              TX_OUT <= parity_bit;
            end else begin
              state  <= ST_STOP;
              TX_OUT <= LINE_IDLE;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state  <= ST_STOP;
            TX_OUT <= LINE_IDLE;
          end
        end
        ST_STOP: begin
          if (tick) begin
            state  <= ST_IDLE;
            TX_OUT <= LINE_IDLE;
            Busy   <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          bit_cnt <= '0;
          TX_OUT  <= LINE_IDLE;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. Expected line waveforms come from a frame
// model that lists the frame's bits and repeats each one max(Prescale,1)
// times. Outputs are sampled on the falling clock edge.
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [7:0] P_Data;
  logic       Data_valid;
  logic       Parity_EN;
  logic       Parity_type;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       Busy;

  int total = 0;
  int bad   = 0;

  bit   exp_q[$];
  logic got_q[$];

  typedef struct {
    logic [7:0] data;
    bit         pen;
    bit         ptype;
    logic [5:0] ps;
    bit         disturb;
    int         exp_cycles;
  } vec_t;

  vec_t vecs[7];
  logic a5_line[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  uart_tx #(
    .DATA_WIDTH     (8),
    .PRESCALE_WIDTH (6)
  ) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .P_Data      (P_Data),
    .Data_valid  (Data_valid),
    .Parity_EN   (Parity_EN),
    .Parity_type (Parity_type),
    .Prescale    (Prescale),
    .TX_OUT      (TX_OUT),
    .Busy        (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the frame as a bit list, each bit stretched to one bit period.
  function automatic void build_frame(input logic [7:0] d, input bit pen, input bit ptype,
                                      input int ps);
    bit bits[$];
    int p;
    p = (ps < 1) ? 1 : ps;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(bit'($countones(d) % 2) ^ ptype);
    bits.push_back(1'b1);
    exp_q.delete();
    foreach (bits[i]) for (int k = 0; k < p; k++) exp_q.push_back(bits[i]);
  endfunction

  task automatic run_frame(input logic [7:0] d, input bit pen, input bit ptype,
                           input logic [5:0] ps, input bit disturb, input int exp_cycles,
                           input string tag);
    int n;
    build_frame(d, pen, ptype, int'(ps));
    @(negedge CLK);
    P_Data = d; Parity_EN = pen; Parity_type = ptype; Prescale = ps; Data_valid = 1'b1;
    @(negedge CLK);
    // Scramble the inputs right after acceptance; the frame must not notice.
    Data_valid = 1'b0; P_Data = ~d; Parity_type = ~ptype; Prescale = ps + 6'd3;
    Parity_EN = ~pen;
    got_q.delete();
    n = 0;
    while (Busy === 1'b1 && n < 2000) begin
      got_q.push_back(TX_OUT);
      if (disturb && n == 2) begin
        Data_valid = 1'b1; P_Data = 8'h81; Parity_type = ~Parity_type; Prescale = 6'd1;
      end
      if (disturb && n == 3) Data_valid = 1'b0;
      n++;
      @(negedge CLK);
    end
    check($sformatf("%s busy_cycles", tag), n, exp_cycles);
    check($sformatf("%s end_busy", tag), Busy, 1'b0);
    check($sformatf("%s end_tx", tag), TX_OUT, 1'b1);
    for (int j = 0; j < exp_q.size(); j++)
      check($sformatf("%s tx[%0d]", tag, j), (j < got_q.size()) ? got_q[j] : 1'bx, exp_q[j]);
    if (disturb) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge CLK);
        check($sformatf("%s no_extra_frame[%0d]", tag, j), {Busy, TX_OUT}, 2'b01);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_tx;
    int exp_busy;
    int k;
    logic [7:0] rd;
    bit rpen, rptype;
    int rps;

    vecs[0] = '{data: 8'hA5, pen: 1'b1, ptype: 1'b0, ps: 6'd1,  disturb: 1'b0, exp_cycles: 11};
    vecs[1] = '{data: 8'h00, pen: 1'b1, ptype: 1'b1, ps: 6'd4,  disturb: 1'b0, exp_cycles: 44};
    vecs[2] = '{data: 8'hFF, pen: 1'b0, ptype: 1'b0, ps: 6'd2,  disturb: 1'b0, exp_cycles: 20};
    vecs[3] = '{data: 8'hFF, pen: 1'b0, ptype: 1'b0, ps: 6'd0,  disturb: 1'b0, exp_cycles: 10};
    vecs[4] = '{data: 8'hFF, pen: 1'b0, ptype: 1'b0, ps: 6'd1,  disturb: 1'b0, exp_cycles: 10};
    vecs[5] = '{data: 8'h3C, pen: 1'b1, ptype: 1'b0, ps: 6'd3,  disturb: 1'b1, exp_cycles: 33};
    vecs[6] = '{data: 8'h6B, pen: 1'b1, ptype: 1'b1, ps: 6'd63, disturb: 1'b0, exp_cycles: 693};

    Reset = 1'b0; P_Data = '0; Data_valid = 1'b0; Parity_EN = 1'b0;
    Parity_type = 1'b0; Prescale = '0;
    #12;
    check("reset tx", TX_OUT, 1'b1);
    check("reset busy", Busy, 1'b0);
    @(negedge CLK);
    Reset = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("idle after reset", {Busy, TX_OUT}, 2'b01);
    end

    // Table-driven frames.
    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].data, vecs[i].pen, vecs[i].ptype, vecs[i].ps, vecs[i].disturb,
                vecs[i].exp_cycles, $sformatf("vec%0d", i));
      if (i == 0)
        for (int j = 0; j < 11; j++)
          check($sformatf("a5 line[%0d]", j), (j < got_q.size()) ? got_q[j] : 1'bx, a5_line[j]);
    end

    // Data_valid held high: frames repeat with one idle-high cycle between.
    build_frame(8'h55, 1'b0, 1'b0, 1);
    @(negedge CLK);
    P_Data = 8'h55; Parity_EN = 1'b0; Parity_type = 1'b0; Prescale = 6'd1; Data_valid = 1'b1;
    for (int c = 0; c < 33; c++) begin
      @(negedge CLK);
      k = c % 11;
      exp_tx   = (k < 10) ? int'(exp_q[k]) : 1;
      exp_busy = (k < 10) ? 1 : 0;
      check($sformatf("b2b tx[%0d]", c), TX_OUT, exp_tx);
      check($sformatf("b2b busy[%0d]", c), Busy, exp_busy);
    end
    Data_valid = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      check("b2b stop", {Busy, TX_OUT}, 2'b01);
    end

    // Reset during data bit 3 of 0x0F.
    build_frame(8'h0F, 1'b0, 1'b0, 4);
    @(negedge CLK);
    P_Data = 8'h0F; Parity_EN = 1'b0; Parity_type = 1'b0; Prescale = 6'd4; Data_valid = 1'b1;
    @(negedge CLK);
    Data_valid = 1'b0;
    repeat (17) @(negedge CLK);
    check("pre-reset busy", Busy, 1'b1);
    check("pre-reset tx", TX_OUT, exp_q[17]);
    #2 Reset = 1'b0;
    #1;
    check("async reset tx", TX_OUT, 1'b1);
    check("async reset busy", Busy, 1'b0);
    repeat (2) @(negedge CLK);
    Reset = 1'b1;
    repeat (6) begin
      @(negedge CLK);
      check("idle after mid-frame reset", {Busy, TX_OUT}, 2'b01);
    end
    run_frame(8'h0F, 1'b0, 1'b0, 6'd4, 1'b0, 40, "post-reset");

    // Randomized frames against the model.
    for (int r = 0; r < 25; r++) begin
      rd     = 8'($urandom);
      rpen   = 1'($urandom_range(0, 1));
      rptype = 1'($urandom_range(0, 1));
      rps    = int'($urandom_range(0, 5));
      run_frame(rd, rpen, rptype, 6'(rps), 1'($urandom_range(0, 1)),
                ((rps < 1) ? 1 : rps) * (10 + int'(rpen)), $sformatf("rand%0d", r));
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
